// File: rtl/core_types_pkg.sv
// Shared core types for the fetch predictor.
// Holds the LHT geometry and ASID width constants, the LHT hash mode, the
// context-update FSM states, and a small integer helper used when sizing
// chunked XOR folds.
package core_types_pkg;

   localparam int LHT_INDEX_WIDTH       = 8;
   localparam int ASID_WIDTH            = 9;
   localparam int LHT_ENTRIES_PER_BLOCK = 2;

   typedef enum logic {
      LHT_HASH_LEGACY = 1'b0,
      LHT_HASH_FOLD   = 1'b1
   } lht_hash_mode_t;

   typedef enum logic [1:0] {
      CTX_RUN   = 2'd0,
      CTX_DRAIN = 2'd1,
      CTX_SWAP  = 2'd2
   } lht_ctx_state_t;

   // Number of w-bit chunks needed to cover n bits.
   function automatic int ceil_div(input int n, input int w);
      return (n + w - 1) / w;
   endfunction

endpackage

// File: rtl/lht_index_fold.sv
// Single-lane LHT index hash (purely combinational).
// Ports:
//   pc_i     [31:0]          fetch PC of this lane
//   asid_i   [ASID_W-1:0]    current address-space id
//   mode_i                   LEGACY: low PC index bits ^ folded ASID
//                            FOLD  : XOR of all index-wide chunks of PC[31:OFFSET] ^ folded ASID
//   index_o  [INDEX_WIDTH-1:0] resulting LHT index
module lht_index_fold
   import core_types_pkg::*;
#(
   parameter int INDEX_WIDTH = LHT_INDEX_WIDTH,
   parameter int OFFSET      = LHT_ENTRIES_PER_BLOCK + 1,
   parameter int ASID_W      = ASID_WIDTH
) (
   input  logic [31:0]            pc_i,
   input  logic [ASID_W-1:0]      asid_i,
   input  lht_hash_mode_t         mode_i,
   output logic [INDEX_WIDTH-1:0] index_o
);

   localparam int PC_BITS = 32 - OFFSET;
   localparam int NPC     = ceil_div(PC_BITS, INDEX_WIDTH);
   localparam int NAS     = ceil_div(ASID_W, INDEX_WIDTH);

   // Zero-extended copies so that the last (partial) chunk reads as zero-padded.
   logic [NPC*INDEX_WIDTH-1:0] pc_ext;
   logic [NAS*INDEX_WIDTH-1:0] asid_ext;
   logic [INDEX_WIDTH-1:0]     pc_fold;
   logic [INDEX_WIDTH-1:0]     asid_fold;

   // PC bits below OFFSET select within a fetch block and never reach the index.
   logic unused_pc_lsb;
   assign unused_pc_lsb = ^pc_i[OFFSET-1:0];

   always_comb begin
      pc_ext                = '0;
      pc_ext[PC_BITS-1:0]   = pc_i[31:OFFSET];
      asid_ext              = '0;
      asid_ext[ASID_W-1:0]  = asid_i;

      asid_fold = '0;
      for (int k = 0; k < NAS; k++) begin
         asid_fold = asid_fold ^ asid_ext[k*INDEX_WIDTH +: INDEX_WIDTH];
      end

      pc_fold = '0;
      for (int k = 0; k < NPC; k++) begin
         pc_fold = pc_fold ^ pc_ext[k*INDEX_WIDTH +: INDEX_WIDTH];
      end

      if (mode_i == LHT_HASH_FOLD) begin
         index_o = pc_fold ^ asid_fold;
      end else begin
         index_o = pc_ext[INDEX_WIDTH-1:0] ^ asid_fold;
      end
   end

endmodule

// File: rtl/lht_index_hash_pipe.sv
// Multi-lane, 2-stage pipelined LHT index hash for the fetch predictor.
// S0 captures the lane PCs and mask on accept; the hash is computed from S0
// into S1, whose registers drive the response. ASID and hash mode live in
// context registers; a context update first drains the pipe so that every
// in-flight request is hashed entirely with the old context.
// Ports:
//   CLK, nRST                          clock, async active-low reset
//   req_valid/req_ready                request handshake
//   req_PC [LANES*32-1:0]              lane l at [l*32 +: 32]
//   req_lane_mask [LANES-1:0]          per-lane valid
//   resp_valid/resp_ready              response handshake
//   resp_index [LANES*INDEX_WIDTH-1:0] lane l at [l*INDEX_WIDTH +: INDEX_WIDTH]
//   resp_lane_mask [LANES-1:0]         mask passed through
//   ctx_update_valid/_ASID/_mode       context change request, held until ready
//   ctx_update_ready                   one-cycle pulse when the new context goes live
module lht_index_hash_pipe
   import core_types_pkg::*;
#(
   parameter int LANES       = 4,
   parameter int INDEX_WIDTH = LHT_INDEX_WIDTH,
   parameter int OFFSET      = LHT_ENTRIES_PER_BLOCK + 1,
   parameter int ASID_W      = ASID_WIDTH
) (
   input  logic                         CLK,
   input  logic                         nRST,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [LANES*32-1:0]          req_PC,
   input  logic [LANES-1:0]             req_lane_mask,
   output logic                         resp_valid,
   input  logic                         resp_ready,
   output logic [LANES*INDEX_WIDTH-1:0] resp_index,
   output logic [LANES-1:0]             resp_lane_mask,
   input  logic                         ctx_update_valid,
   input  logic [ASID_W-1:0]            ctx_update_ASID,
   input  logic                         ctx_update_mode,
   output logic                         ctx_update_ready
);

   // Context registers and FSM
   lht_ctx_state_t   state_q;
   logic [ASID_W-1:0] asid_q;
   lht_hash_mode_t   mode_q;
   logic             ctx_rdy_q;

   // Pipeline registers
   logic                         s0_valid_q, s0_valid_d;
   logic [LANES*32-1:0]          s0_pc_q,    s0_pc_d;
   logic [LANES-1:0]             s0_mask_q,  s0_mask_d;
   logic                         s1_valid_q, s1_valid_d;
   logic [LANES*INDEX_WIDTH-1:0] s1_index_q, s1_index_d;
   logic [LANES-1:0]             s1_mask_q,  s1_mask_d;

   logic s1_adv, s0_adv, req_fire, drain_done;
   logic [LANES*INDEX_WIDTH-1:0] lane_idx;

   assign s1_adv     = !s1_valid_q || resp_ready;
   assign s0_adv     = s0_valid_q && s1_adv;
   // An update request closes the input in the same cycle so no request can
   // slip in between the decision to drain and the context swap.
   assign req_ready  = (state_q == CTX_RUN) && !ctx_update_valid && (!s0_valid_q || s1_adv);
   assign req_fire   = req_valid && req_ready;
   // Pipe is empty as of the next edge: S0 empty and S1 empty or leaving now.
   assign drain_done = !s0_valid_q && (!s1_valid_q || resp_ready);

   assign resp_valid       = s1_valid_q;
   assign resp_index       = s1_index_q;
   assign resp_lane_mask   = s1_mask_q;
   assign ctx_update_ready = ctx_rdy_q;

   // ---- S0 -> S1: per-lane hash with the live context ----
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      lht_index_fold #(
         .INDEX_WIDTH (INDEX_WIDTH),
         .OFFSET      (OFFSET),
         .ASID_W      (ASID_W)
      ) u_fold (
         .pc_i    (s0_pc_q[l*32 +: 32]),
         .asid_i  (asid_q),
         .mode_i  (mode_q),
         .index_o (lane_idx[l*INDEX_WIDTH +: INDEX_WIDTH])
      );
   end

   always_comb begin
      s0_valid_d = s0_valid_q;
      s0_pc_d    = s0_pc_q;
      s0_mask_d  = s0_mask_q;
      // req_fire already implies S0 is empty or moving on this cycle.
      if (req_fire) begin
         s0_valid_d = 1'b1;
         s0_pc_d    = req_PC;
         s0_mask_d  = req_lane_mask;
      end else if (s0_adv) begin
         s0_valid_d = 1'b0;
      end

      s1_valid_d = s1_valid_q;
      s1_index_d = s1_index_q;
      s1_mask_d  = s1_mask_q;
      if (s0_adv) begin
         s1_valid_d = 1'b1;
         s1_mask_d  = s0_mask_q;
         for (int l = 0; l < LANES; l++) begin
            s1_index_d[l*INDEX_WIDTH +: INDEX_WIDTH] =
               s0_mask_q[l] ? lane_idx[l*INDEX_WIDTH +: INDEX_WIDTH] : '0;
         end
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
   end

   // ---- pipeline register update ----
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         s0_valid_q <= 1'b0;
         s0_pc_q    <= '0;
         s0_mask_q  <= '0;
         s1_valid_q <= 1'b0;
         s1_index_q <= '0;
         s1_mask_q  <= '0;
      end else begin
         s0_valid_q <= s0_valid_d;
         s0_pc_q    <= s0_pc_d;
         s0_mask_q  <= s0_mask_d;
         s1_valid_q <= s1_valid_d;
         s1_index_q <= s1_index_d;
         s1_mask_q  <= s1_mask_d;
      end
   end

   // ---- context FSM: RUN -> DRAIN -> SWAP -> RUN ----
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= CTX_RUN;
         asid_q    <= '0;
         mode_q    <= LHT_HASH_LEGACY;
         ctx_rdy_q <= 1'b0;
      end else begin
         ctx_rdy_q <= 1'b0;
         case (state_q)
            CTX_RUN: begin
               if (ctx_update_valid) state_q <= CTX_DRAIN;
            end
            CTX_DRAIN: begin
               // A withdrawn update leaves the context untouched.
               if (!ctx_update_valid) begin
                  state_q <= CTX_RUN;
               end else if (drain_done) begin
                  state_q   <= CTX_SWAP;
                  ctx_rdy_q <= 1'b1;
               end
            end
            CTX_SWAP: begin
               asid_q  <= ctx_update_ASID;
               mode_q  <= lht_hash_mode_t'(ctx_update_mode);
               state_q <= CTX_RUN;
            end
            default: state_q <= CTX_RUN;
         endcase
      end
   end

endmodule
